// File: rtl/wait_cond_monitor.sv
// wait_cond_monitor
//   Multi-channel hardware wait engine. Each channel is armed with a signed
//   comparison against its watched value. It then waits until the condition
//   holds (done pulse), its timeout expires (tmo pulse), or it is cancelled.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   obs          CHANNELS*WIDTH watched values, channel i at obs[i*WIDTH +: WIDTH]
//   arm_*        arm request: valid/ready handshake, channel, op, lo, hi, timeout
//   cancel       per-channel abort (ignored on idle channels)
//   busy         channel is waiting
//   done / tmo   registered one-cycle completion / timeout pulses

module wait_cond_chan #(
    parameter int WIDTH = 32,
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] obs,
    input  logic             arm,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [TMO_W-1:0] tmo_in,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             tmo
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] lo_q, hi_q;
    logic [TMO_W-1:0] cnt_q;
    logic             inf_q;
    logic             fire_done, fire_tmo, cond;

    logic signed [WIDTH-1:0] x, l, h;
    assign x = $signed(obs);
    assign l = $signed(lo_q);
    assign h = $signed(hi_q);

    // With lo >= hi, IN can never hold and OUT always holds; no special case needed.
    always_comb begin
        cond = 1'b0;
        case (op_q)
            3'd0:    cond = (x == l);
            3'd1:    cond = (x != l);
            3'd2:    cond = (x <  l);
            3'd3:    cond = (x <= l);
            3'd4:    cond = (x >  l);
            3'd5:    cond = (x >= l);
            3'd6:    cond = (x >  l) && (x <  h);
            default: cond = (x <= l) || (x >= h);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        fire_done = 1'b0;
        fire_tmo  = 1'b0;
        case (state_q)
            IDLE: if (arm) state_d = WAIT;
            WAIT: begin
                if (cancel) begin
                    state_d = IDLE;
                end else if (cond) begin
                    state_d   = IDLE;
                    fire_done = 1'b1;
                end else if (!inf_q && cnt_q == TMO_W'(1)) begin
                    state_d  = IDLE;
                    fire_tmo = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            lo_q  <= '0;
            hi_q  <= '0;
            cnt_q <= '0;
            inf_q <= 1'b0;
            done  <= 1'b0;
            tmo   <= 1'b0;
        end else begin
            done <= fire_done;
            tmo  <= fire_tmo;
            if (state_q == IDLE && arm) begin
                op_q  <= op;
                lo_q  <= lo;
                hi_q  <= hi;
                cnt_q <= tmo_in;
                inf_q <= (tmo_in == '0);
            end else if (state_q == WAIT && state_d == WAIT && !inf_q) begin
                cnt_q <= cnt_q - TMO_W'(1);
            end
        end
    end

    assign busy = (state_q == WAIT);
endmodule

module wait_cond_monitor #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int TMO_W    = 16,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] obs,
    input  logic                      arm_valid,
    output logic                      arm_ready,
    input  logic [CW-1:0]             arm_chan,
    input  logic [2:0]                arm_op,
    input  logic [WIDTH-1:0]          arm_lo,
    input  logic [WIDTH-1:0]          arm_hi,
    input  logic [TMO_W-1:0]          arm_tmo,
    input  logic [CHANNELS-1:0]       cancel,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       tmo
);
    localparam int NPAD = 1 << CW;

    // Padded to the full arm_chan range so an out-of-range index reads as "not idle".
    logic [NPAD-1:0] idle_pad, cancel_pad;
    logic            chan_ok;

    always_comb begin
        idle_pad   = '0;
        cancel_pad = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idle_pad[i]   = ~busy[i];
            cancel_pad[i] = cancel[i];
        end
    end

    assign chan_ok   = (int'(arm_chan) < CHANNELS);
    assign arm_ready = chan_ok && idle_pad[arm_chan] && !cancel_pad[arm_chan];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic arm_go;
        assign arm_go = arm_valid && arm_ready && (arm_chan == CW'(i));

        wait_cond_chan #(.WIDTH(WIDTH), .TMO_W(TMO_W)) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .obs    (obs[i*WIDTH +: WIDTH]),
            .arm    (arm_go),
            .op     (arm_op),
            .lo     (arm_lo),
            .hi     (arm_hi),
            .tmo_in (arm_tmo),
            .cancel (cancel[i]),
            .busy   (busy[i]),
            .done   (done[i]),
            .tmo    (tmo[i])
        );
    end
endmodule

// File: tb/tb_wait_cond_monitor.sv
module tb_wait_cond_monitor;
    localparam int W = 32;
    localparam int N = 4;
    localparam int T = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] obs;
    logic           arm_valid, arm_ready;
    logic [1:0]     arm_chan;
    logic [2:0]     arm_op;
    logic [W-1:0]   arm_lo, arm_hi;
    logic [T-1:0]   arm_tmo;
    logic [N-1:0]   cancel, busy, done, tmo;

    // 3-channel instance: exercises an arm_chan value beyond CHANNELS.
    logic [3*W-1:0] obs3 = '0;
    logic [1:0]     chan3;
    logic           ready3;
    logic [2:0]     busy3, done3, tmo3;

    int n_chk = 0;
    int n_fail = 0;

    wait_cond_monitor #(.WIDTH(W), .CHANNELS(N), .TMO_W(T)) dut (
        .clk(clk), .rst_n(rst_n), .obs(obs), .arm_valid(arm_valid), .arm_ready(arm_ready),
        .arm_chan(arm_chan), .arm_op(arm_op), .arm_lo(arm_lo), .arm_hi(arm_hi),
        .arm_tmo(arm_tmo), .cancel(cancel), .busy(busy), .done(done), .tmo(tmo)
    );

    wait_cond_monitor #(.WIDTH(W), .CHANNELS(3), .TMO_W(T)) dut3 (
        .clk(clk), .rst_n(rst_n), .obs(obs3), .arm_valid(1'b0), .arm_ready(ready3),
        .arm_chan(chan3), .arm_op(3'd0), .arm_lo('0), .arm_hi('0),
        .arm_tmo('0), .cancel(3'b000), .busy(busy3), .done(done3), .tmo(tmo3)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_obs(input int ch, input int val);
        obs[ch*W +: W] = val;
    endtask

    // Presents an arm, checks it is ready, and returns #1 after the accepting edge.
    task automatic arm(input int ch, input int op, input int lo, input int hi, input int t);
        arm_valid = 1'b1;
        arm_chan  = 2'(ch);
        arm_op    = 3'(op);
        arm_lo    = lo;
        arm_hi    = hi;
        arm_tmo   = T'(t);
        #1;
        chk($sformatf("arm_ready ch%0d", ch), {31'b0, arm_ready}, 32'd1);
        tick();
        arm_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; obs = '0; arm_valid = 1'b0; arm_chan = '0; arm_op = '0;
        arm_lo = '0; arm_hi = '0; arm_tmo = '0; cancel = '0; chan3 = '0;
        tick(); tick();
        chk("rst busy", {28'b0, busy}, 32'h0);
        chk("rst done", {28'b0, done}, 32'h0);
        chk("rst tmo",  {28'b0, tmo},  32'h0);
        rst_n = 1'b1;
        tick();
        chk("idle arm_ready", {31'b0, arm_ready}, 32'd1);

        // EQ wait on ch0, forever timeout
        arm(0, 0, 2, 0, 0);
        chk("eq busy after arm", {28'b0, busy}, 32'h1);
        set_obs(0, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("eq waiting busy", {28'b0, busy}, 32'h1);
            chk("eq waiting done", {28'b0, done}, 32'h0);
        end
        set_obs(0, 2);
        tick();
        chk("eq done", {28'b0, done}, 32'h1);
        chk("eq busy fell", {28'b0, busy}, 32'h0);
        chk("eq no tmo", {28'b0, tmo}, 32'h0);
        tick();
        chk("eq done one cycle", {28'b0, done}, 32'h0);

        // Immediate IN on ch1, then back-to-back LT re-arm
        set_obs(1, 2);
        arm(1, 6, 1, 3, 0);
        chk("in busy", {28'b0, busy}, 32'h2);
        chk("in no early done", {28'b0, done}, 32'h0);
        tick();
        chk("in done", {28'b0, done}, 32'h2);
        arm(1, 2, 2, 0, 0);
        chk("lt busy", {28'b0, busy}, 32'h2);
        chk("lt no done", {28'b0, done}, 32'h0);
        set_obs(1, 1);
        tick();
        chk("lt done", {28'b0, done}, 32'h2);
        tick();

        // Signed GT with timeout on ch2
        set_obs(2, -3);
        arm(2, 4, -1, 0, 5);
        for (int k = 1; k < 5; k++) begin
            tick();
            chk("gt pre-timeout tmo", {28'b0, tmo}, 32'h0);
            chk("gt pre-timeout busy", {28'b0, busy}, 32'h4);
        end
        tick();
        chk("gt tmo", {28'b0, tmo}, 32'h4);
        chk("gt tmo no done", {28'b0, done}, 32'h0);
        chk("gt tmo busy", {28'b0, busy}, 32'h0);
        tick();
        chk("gt tmo one cycle", {28'b0, tmo}, 32'h0);
        arm(2, 4, -1, 0, 5);
        for (int k = 1; k < 5; k++) tick();
        set_obs(2, 0);
        tick();
        chk("gt done wins", {28'b0, done}, 32'h4);
        chk("gt done wins tmo", {28'b0, tmo}, 32'h0);
        // Timeout of 1: tmo after the first edge, unless the condition holds
        set_obs(2, -3);
        arm(2, 4, -1, 0, 1);
        tick();
        chk("tmo1 tmo", {28'b0, tmo}, 32'h4);
        set_obs(2, 5);
        arm(2, 4, -1, 0, 1);
        tick();
        chk("tmo1 done", {28'b0, done}, 32'h4);
        chk("tmo1 no tmo", {28'b0, tmo}, 32'h0);
        // OUT with lo >= hi is always true
        set_obs(2, 0);
        arm(2, 7, 5, 5, 0);
        tick();
        chk("out degenerate done", {28'b0, done}, 32'h4);
        tick();

        // Cancel beats condition on ch3
        arm(3, 0, 4, 0, 0);
        tick();
        set_obs(3, 4);
        cancel = 4'b1000;
        tick();
        chk("cancel busy", {28'b0, busy}, 32'h0);
        tick();
        chk("cancel no done", {28'b0, done}, 32'h0);
        chk("cancel no tmo", {28'b0, tmo}, 32'h0);
        arm_valid = 1'b1; arm_chan = 2'd3;
        #1;
        chk("arm blocked by cancel", {31'b0, arm_ready}, 32'd0);
        tick();
        chk("cancelled arm not taken", {28'b0, busy}, 32'h0);
        arm_valid = 1'b0; cancel = '0;

        // Concurrency and backpressure
        obs = '0;
        for (int c = 0; c < 4; c++) arm(c, 0, 7, 0, 0);
        chk("all busy", {28'b0, busy}, 32'hF);
        arm_valid = 1'b1; arm_chan = 2'd1;
        #1;
        chk("busy chan not ready", {31'b0, arm_ready}, 32'd0);
        arm_valid = 1'b0;
        chan3 = 2'd2;
        #1;
        chk("3ch in-range ready", {31'b0, ready3}, 32'd1);
        chan3 = 2'd3;
        #1;
        chk("3ch out-of-range ready", {31'b0, ready3}, 32'd0);
        for (int c = 0; c < 4; c++) set_obs(c, 7);
        tick();
        chk("all done together", {28'b0, done}, 32'hF);
        chk("all idle", {28'b0, busy}, 32'h0);
        tick();
        chk("all done one cycle", {28'b0, done}, 32'h0);

        // Reset mid-wait
        obs = '0;
        for (int c = 0; c < 3; c++) arm(c, 0, 9, 0, 0);
        chk("three busy", {28'b0, busy}, 32'h7);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst busy", {28'b0, busy}, 32'h0);
        chk("async rst done", {28'b0, done}, 32'h0);
        chk("async rst tmo",  {28'b0, tmo},  32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post rst no pulse", {28'b0, done | tmo}, 32'h0);
        set_obs(0, 5);
        arm(0, 0, 5, 0, 0);
        chk("post rst busy", {28'b0, busy}, 32'h1);
        tick();
        chk("post rst done", {28'b0, done}, 32'h1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
